// File: rtl/m_uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: parity codes, FSM
// state encoding and the parity helper. The RX path can reuse this package.
package m_uart_tx_fifo_pkg;

    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_ODD  = 1;
    localparam int UART_PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // XOR of the data bits is the even-parity bit; odd parity inverts it
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == UART_PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/m_uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, occupancy count
// and full/empty flags. Push while full and pop while empty are ignored.
module m_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array: written on accepted pushes, needs no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/m_uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, then an FSM
// that serialises each word LSB-first with optional parity and 1 or 2 stop bits.
module m_uart_tx_fifo
    import m_uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic                          w_we,
    input  logic [DATA_BITS-1:0]          w_data_in,
    output logic                          w_ready,
    output logic                          w_busy,
    output logic [$clog2(FIFO_DEPTH):0]   w_fifo_cnt,
    output logic                          r_ovf,
    output logic                          r_tx
);

    // Reject illegal configurations at elaboration
    if (CLK_DIV < 2 || CLK_DIV > 1023) begin : g_bad_clk_div
        $error("m_uart_tx_fifo: CLK_DIV must be 2..1023");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("m_uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY != UART_PAR_NONE && PARITY != UART_PAR_ODD && PARITY != UART_PAR_EVEN) begin : g_bad_parity
        $error("m_uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("m_uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("m_uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
    end

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e              state_q;
    logic [BAUD_W-1:0]      baud_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   r_tx_q;
    logic                   r_ovf_q;

    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   baud_end;
    logic                   stop_done;
    logic                   pop;

    m_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (w_clk),
        .rst_ni  (w_rst_n),
        .push_i  (w_we),
        .wdata_i (w_data_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (w_fifo_cnt)
    );

    // The baud counter wraps at CLK_DIV-1, so every bit lasts CLK_DIV cycles
    assign baud_end  = (baud_q == BAUD_LAST);
    // Last cycle of the last stop bit: the point where a queued word can start
    assign stop_done = (state_q == ST_STOP) && baud_end && (bit_idx_q == STOP_LAST);
    // Pop from idle, or back-to-back at the end of the final stop bit
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || stop_done);

    assign w_ready = !fifo_full;
    assign w_busy  = (state_q != ST_IDLE) || !fifo_empty;
    assign r_tx    = r_tx_q;
    assign r_ovf   = r_ovf_q;

    // Frame FSM: line level is registered alongside every state change
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            r_tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    r_tx_q <= 1'b1;
                    if (pop) begin
                        state_q   <= ST_START;
                        shift_q   <= fifo_rdata;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        par_q     <= 1'b0;
                        r_tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        state_q   <= ST_DATA;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        r_tx_q    <= shift_q[0];
                        par_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            if (PARITY != UART_PAR_NONE) begin
                                state_q <= ST_PARITY;
                                r_tx_q  <= parity_bit(par_q, PARITY);
                            end else begin
                                state_q <= ST_STOP;
                                r_tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            r_tx_q    <= shift_q[0];
                            par_q     <= par_q ^ shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        state_q   <= ST_STOP;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        r_tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_q <= '0;
                            if (pop) begin
                                state_q <= ST_START;
                                shift_q <= fifo_rdata;
                                par_q   <= 1'b0;
                                r_tx_q  <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                r_tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    r_tx_q  <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow flag: a write that found the FIFO full; cleared by reset only
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ovf_q <= 1'b0;
        end else if (w_we && fifo_full) begin
            r_ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m_uart_tx_fifo.sv
// Bench for m_uart_tx_fifo: six instances with different frame formats share
// one clock and reset. A queue-based model predicts the line level and status
// outputs for every cycle from frame arithmetic.
module tb_m_uart_tx_fifo;

    localparam int NI = 6;
    localparam int CD_T  [NI] = '{4, 4, 4, 4, 4, 50};
    localparam int DB_T  [NI] = '{8, 8, 8, 7, 8, 8};
    localparam int PAR_T [NI] = '{0, 2, 1, 2, 0, 0};
    localparam int SB_T  [NI] = '{1, 1, 1, 2, 1, 1};
    localparam int FD_T  [NI] = '{16, 16, 16, 16, 4, 16};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] we = '0;
    logic [7:0]    din [NI];
    wire  [NI-1:0] tx_w, rdy_w, busy_w, ovf_w;
    wire  [4:0]    cnt0, cnt1, cnt2, cnt3, cnt5;
    wire  [2:0]    cnt4;

    int nvec = 0;
    int nerr = 0;
    bit m_ovf [NI];
    int stim_we [];
    int stim_d  [];

    always #5 clk = ~clk;

    m_uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d0 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[0]), .w_data_in(din[0]), .w_ready(rdy_w[0]),
        .w_busy(busy_w[0]), .w_fifo_cnt(cnt0), .r_ovf(ovf_w[0]), .r_tx(tx_w[0]));
    m_uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d1 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[1]), .w_data_in(din[1]), .w_ready(rdy_w[1]),
        .w_busy(busy_w[1]), .w_fifo_cnt(cnt1), .r_ovf(ovf_w[1]), .r_tx(tx_w[1]));
    m_uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d2 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[2]), .w_data_in(din[2]), .w_ready(rdy_w[2]),
        .w_busy(busy_w[2]), .w_fifo_cnt(cnt2), .r_ovf(ovf_w[2]), .r_tx(tx_w[2]));
    m_uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d3 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[3]), .w_data_in(din[3][6:0]), .w_ready(rdy_w[3]),
        .w_busy(busy_w[3]), .w_fifo_cnt(cnt3), .r_ovf(ovf_w[3]), .r_tx(tx_w[3]));
    m_uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d4 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[4]), .w_data_in(din[4]), .w_ready(rdy_w[4]),
        .w_busy(busy_w[4]), .w_fifo_cnt(cnt4), .r_ovf(ovf_w[4]), .r_tx(tx_w[4]));
    m_uart_tx_fifo #(.CLK_DIV(50), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d5 (
        .w_clk(clk), .w_rst_n(rst_n), .w_we(we[5]), .w_data_in(din[5]), .w_ready(rdy_w[5]),
        .w_busy(busy_w[5]), .w_fifo_cnt(cnt5), .r_ovf(ovf_w[5]), .r_tx(tx_w[5]));

    function automatic logic [31:0] get_cnt(input int g);
        case (g)
            0:       return {27'b0, cnt0};
            1:       return {27'b0, cnt1};
            2:       return {27'b0, cnt2};
            3:       return {27'b0, cnt3};
            4:       return {29'b0, cnt4};
            default: return {27'b0, cnt5};
        endcase
    endfunction

    // Whole-frame length in clock cycles
    function automatic int flen(input int g);
        return (1 + DB_T[g] + ((PAR_T[g] != 0) ? 1 : 0) + SB_T[g]) * CD_T[g];
    endfunction

    // Line level of bit slot b of a frame carrying word w
    function automatic logic frame_bit(input int g, input int w, input int b);
        int ones;
        if (b == 0) return 1'b0;
        if (b <= DB_T[g]) return w[b-1];
        if (PAR_T[g] != 0 && b == DB_T[g] + 1) begin
            ones = $countones(w);
            return (PAR_T[g] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input int g, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s inst%0d cyc%0d: observed %0h expected %0h", tag, g, k, obs, exp);
        end
    endtask

    task automatic clear_stim(input int n);
        stim_we = new[n];
        stim_d  = new[n];
    endtask

    task automatic gen_random(input int g, input int nw, input int maxgap, output int n);
        int pos [$];
        int t;
        t = $urandom_range(0, 3);
        for (int i = 0; i < nw; i++) begin
            pos.push_back(t);
            t += $urandom_range(0, maxgap) + 1;
        end
        n = t + (nw + 1) * flen(g) + 10;
        clear_stim(n);
        foreach (pos[i]) begin
            stim_we[pos[i]] = 1;
            stim_d[pos[i]]  = int'($urandom) & ((1 << DB_T[g]) - 1);
        end
    endtask

    // Apply stim_* to instance g for n cycles, checking every cycle
    task automatic run_scenario(input int g, input int n);
        int   q [$];
        int   line_end, pop_edge, cur, len, fl;
        logic e_tx;
        fl = flen(g);
        line_end = 0;
        pop_edge = -1;
        cur = 0;
        for (int k = 0; k < n; k++) begin
            we[g]  = (stim_we[k] != 0);
            din[g] = stim_d[k][7:0];
            len = q.size();
            if (k >= line_end && len > 0) begin
                cur = q.pop_front();
                pop_edge = k;
                line_end = k + fl;
            end
            if (stim_we[k] != 0) begin
                if (len < FD_T[g]) q.push_back(stim_d[k]);
                else m_ovf[g] = 1'b1;
            end
            if (pop_edge >= 0 && k < line_end) e_tx = frame_bit(g, cur, (k - pop_edge) / CD_T[g]);
            else e_tx = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("tx",    g, k, tx_w[g],   e_tx);
            chk("cnt",   g, k, get_cnt(g), q.size());
            chk("ready", g, k, rdy_w[g],  q.size() != FD_T[g]);
            chk("busy",  g, k, busy_w[g], (k < line_end) || (q.size() != 0));
            chk("ovf",   g, k, ovf_w[g],  m_ovf[g]);
        end
        we[g] = 1'b0;
    endtask

    task automatic chk_reset_state(input int k);
        for (int g = 0; g < NI; g++) begin
            chk("rst_tx",    g, k, tx_w[g],    1);
            chk("rst_cnt",   g, k, get_cnt(g), 0);
            chk("rst_ready", g, k, rdy_w[g],   1);
            chk("rst_busy",  g, k, busy_w[g],  0);
            chk("rst_ovf",   g, k, ovf_w[g],   0);
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < NI; g++) begin
            din[g] = 8'h00;
            m_ovf[g] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_state(0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 frame of 8'h61
        clear_stim(60);
        stim_we[0] = 1; stim_d[0] = 'h61;
        run_scenario(0, 60);

        // Parity frames and 7E2
        clear_stim(55);
        stim_we[0] = 1; stim_d[0] = 'h07;
        run_scenario(1, 55);
        run_scenario(2, 55);
        clear_stim(55);
        stim_we[0] = 1; stim_d[0] = 'h55;
        run_scenario(3, 55);

        // Three-word burst, frames back to back
        clear_stim(130);
        stim_we[0] = 1; stim_d[0] = 'hA5;
        stim_we[1] = 1; stim_d[1] = 'h5A;
        stim_we[2] = 1; stim_d[2] = 'hFF;
        run_scenario(0, 130);

        // Depth-4 FIFO, six back-to-back writes: the sixth overflows
        clear_stim(220);
        for (int i = 0; i < 6; i++) begin
            stim_we[i] = 1;
            stim_d[i]  = int'($urandom_range(0, 255));
        end
        run_scenario(4, 220);

        // Reset in the middle of the second of three queued frames
        clear_stim(55);
        for (int i = 0; i < 3; i++) begin
            stim_we[i] = 1;
            stim_d[i]  = int'($urandom_range(0, 255));
        end
        run_scenario(0, 55);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",   0, 55, tx_w[0],   1);
        chk("mid_rst_cnt",  0, 55, get_cnt(0), 0);
        chk("mid_rst_busy", 0, 55, busy_w[0], 0);
        chk("mid_rst_ovf",  4, 55, ovf_w[4],  0);
        for (int g = 0; g < NI; g++) m_ovf[g] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stim(60);
        run_scenario(0, 60);

        // Slow baud: 8'h00 at CLK_DIV=50
        clear_stim(520);
        stim_we[0] = 1; stim_d[0] = 'h00;
        run_scenario(5, 520);

        // Randomised words and gaps on each fast instance
        for (int g = 0; g < 5; g++) begin
            gen_random(g, 6, (g == 4) ? 1 : 2 * flen(g), n);
            run_scenario(g, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
